// File: rtl/alu_seq_ctrl_pkg.sv
// rtl/alu_seq_ctrl_pkg.sv - shared constants and types for the ALU control sequencer
//
// Purpose: state encoding, opcode constants and the latched-command record
// shared by the sequencer, its interface and the decoder.
// Ports: none (package).
package alu_seq_ctrl_pkg;

  localparam int NREG  = 16;
  localparam int OP_W  = 5;
  localparam int IDX_W = 4;

  localparam logic [OP_W-1:0] OP_SLL = 5'b00011;
  localparam logic [OP_W-1:0] OP_ADD = 5'b00101;
  localparam logic [OP_W-1:0] OP_MUL = 5'b01110;
  localparam logic [OP_W-1:0] OP_DIV = 5'b01111;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_Y = 3'd1,
    ST_EXEC   = 3'd2,
    ST_WR_LO  = 3'd3,
    ST_WR_HI  = 3'd4
  } state_e;

  // Command captured on the accepting edge; the strobes use only this copy.
  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [IDX_W-1:0] ra;
    logic [IDX_W-1:0] rb;
    logic [IDX_W-1:0] rd;
  } cmd_t;

  // MUL/DIV produce a 64-bit result that is written to HI/LO instead of rd.
  function automatic logic is_hilo_op(input logic [OP_W-1:0] op,
                                      input logic [OP_W-1:0] mul_op,
                                      input logic [OP_W-1:0] div_op);
    return (op == mul_op) || (op == div_op);
  endfunction

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// rtl/alu_seq_ctrl_if.sv - command and datapath-strobe bundle for the ALU sequencer
//
// Purpose: groups the command handshake (start/ready/done plus op/ra/rb/rd)
// and every datapath strobe the sequencer drives.
// Modports:
//   master - command source (decoder or bench): drives start, op_in, ra, rb, rd
//   slave  - sequencer: drives ready, done, Rout, Rin, Yin, Z*/HI/LO strobes, op
interface alu_seq_ctrl_if
  import alu_seq_ctrl_pkg::*;
#(
  parameter int NREG = alu_seq_ctrl_pkg::NREG,
  parameter int OP_W = alu_seq_ctrl_pkg::OP_W
) ();

  logic            start;
  logic [OP_W-1:0] op_in;
  logic [3:0]      ra;
  logic [3:0]      rb;
  logic [3:0]      rd;

  logic            ready;
  logic            done;
  logic [NREG-1:0] Rout;
  logic [NREG-1:0] Rin;
  logic            Yin;
  logic            Zhighin;
  logic            Zlowin;
  logic            Zhighout;
  logic            Zlowout;
  logic            HIin;
  logic            LOin;
  logic [OP_W-1:0] op;

  modport master (
    output start, op_in, ra, rb, rd,
    input  ready, done, Rout, Rin, Yin, Zhighin, Zlowin,
           Zhighout, Zlowout, HIin, LOin, op
  );

  modport slave (
    input  start, op_in, ra, rb, rd,
    output ready, done, Rout, Rin, Yin, Zhighin, Zlowin,
           Zhighout, Zlowout, HIin, LOin, op
  );

endinterface

// File: rtl/alu_seq_ctrl_onehot_dec4.sv
// rtl/alu_seq_ctrl_onehot_dec4.sv - 4-bit index to one-hot decoder with enable
//
// Purpose: turns a register index into a one-hot strobe vector.
// Ports:
//   idx_i    in  4 : register index
//   en_i     in  1 : when 0 the output is all zeros
//   onehot_o out N : one-hot of idx_i, or zero
module onehot_dec4 #(
  parameter int N = 16
) (
  input  logic [3:0]   idx_i,
  input  logic         en_i,
  output logic [N-1:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) begin
      onehot_o = N'(1) << idx_i;
    end
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - Moore control sequencer for the register/ALU datapath
//
// Purpose: accepts one register-register ALU command at a time and steps the
// datapath through LOAD_Y -> EXEC -> WR_LO [-> WR_HI], driving one-hot
// register strobes, Y/Z enables, HI/LO loads and the ALU opcode.
// Ports:
//   Clock in : sole clock, rising edge
//   clear in : asynchronous active-high reset
//   bus       : alu_seq_ctrl_if.slave (command in, ready/done and strobes out)
// All outputs come straight from flops so they stay stable across the
// datapath capture edge that follows.
module alu_seq_ctrl
  import alu_seq_ctrl_pkg::*;
#(
  parameter int              NREG   = alu_seq_ctrl_pkg::NREG,
  parameter int              OP_W   = alu_seq_ctrl_pkg::OP_W,
  parameter logic [OP_W-1:0] OP_MUL = alu_seq_ctrl_pkg::OP_MUL,
  parameter logic [OP_W-1:0] OP_DIV = alu_seq_ctrl_pkg::OP_DIV
) (
  input logic           Clock,
  input logic           clear,
  alu_seq_ctrl_if.slave bus
);

  state_e state_q, state_d;
  cmd_t   cmd_q, cmd_d;

  // Registered output copies (next-state values computed below).
  logic            ready_q, ready_d;
  logic            done_q, done_d;
  logic [NREG-1:0] rout_q, rout_d;
  logic [NREG-1:0] rin_q, rin_d;
  logic            yin_q, yin_d;
  logic            zin_q, zin_d;
  logic            zhighout_q, zhighout_d;
  logic            zlowout_q, zlowout_d;
  logic            hiin_q, hiin_d;
  logic            loin_q, loin_d;
  logic [OP_W-1:0] op_q, op_d;

  // Decoder controls for the state being entered.
  logic       rout_en_d;
  logic [3:0] rout_idx_d;
  logic       rin_en_d;

  // Next-state logic. The command is latched only on the accepting edge.
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          cmd_d.op = bus.op_in;
          cmd_d.ra = bus.ra;
          cmd_d.rb = bus.rb;
          cmd_d.rd = bus.rd;
          state_d  = ST_LOAD_Y;
        end
      end
      ST_LOAD_Y: state_d = ST_EXEC;
      ST_EXEC:   state_d = ST_WR_LO;
      ST_WR_LO: begin
        if (is_hilo_op(cmd_q.op, OP_MUL, OP_DIV)) begin
          state_d = ST_WR_HI;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WR_HI:  state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output decode for the state about to be entered, so the flopped outputs
  // line up with that state. cmd_d carries the freshly accepted command in
  // the LOAD_Y entry cycle.
  always_comb begin
    ready_d    = 1'b0;
    done_d     = 1'b0;
    rout_en_d  = 1'b0;
    rout_idx_d = cmd_d.ra;
    rin_en_d   = 1'b0;
    yin_d      = 1'b0;
    zin_d      = 1'b0;
    zhighout_d = 1'b0;
    zlowout_d  = 1'b0;
    hiin_d     = 1'b0;
    loin_d     = 1'b0;
    op_d       = '0;
    unique case (state_d)
      ST_IDLE: ready_d = 1'b1;
      ST_LOAD_Y: begin
        rout_en_d  = 1'b1;
        rout_idx_d = cmd_d.ra;
        yin_d      = 1'b1;
      end
      ST_EXEC: begin
        rout_en_d  = 1'b1;
        rout_idx_d = cmd_d.rb;
        op_d       = cmd_d.op;
        zin_d      = 1'b1;
      end
      ST_WR_LO: begin
        zlowout_d = 1'b1;
        if (is_hilo_op(cmd_d.op, OP_MUL, OP_DIV)) begin
          loin_d = 1'b1;
        end else begin
          rin_en_d = 1'b1;
          done_d   = 1'b1;
        end
      end
      ST_WR_HI: begin
        zhighout_d = 1'b1;
        hiin_d     = 1'b1;
        done_d     = 1'b1;
      end
      default: ready_d = 1'b0;
    endcase
  end

  onehot_dec4 #(.N(NREG)) u_rout_dec (
    .idx_i    (rout_idx_d),
    .en_i     (rout_en_d),
    .onehot_o (rout_d)
  );

  onehot_dec4 #(.N(NREG)) u_rin_dec (
    .idx_i    (cmd_d.rd),
    .en_i     (rin_en_d),
    .onehot_o (rin_d)
  );

  always_ff @(posedge Clock or posedge clear) begin
    if (clear) begin
      state_q    <= ST_IDLE;
      cmd_q      <= '0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      rout_q     <= '0;
      rin_q      <= '0;
      yin_q      <= 1'b0;
      zin_q      <= 1'b0;
      zhighout_q <= 1'b0;
      zlowout_q  <= 1'b0;
      hiin_q     <= 1'b0;
      loin_q     <= 1'b0;
      op_q       <= '0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      rout_q     <= rout_d;
      rin_q      <= rin_d;
      yin_q      <= yin_d;
      zin_q      <= zin_d;
      zhighout_q <= zhighout_d;
      zlowout_q  <= zlowout_d;
      hiin_q     <= hiin_d;
      loin_q     <= loin_d;
      op_q       <= op_d;
    end
  end

  assign bus.ready    = ready_q;
  assign bus.done     = done_q;
  assign bus.Rout     = rout_q;
  assign bus.Rin      = rin_q;
  assign bus.Yin      = yin_q;
  // Both Z halves always load together in EXEC.
  assign bus.Zhighin  = zin_q;
  assign bus.Zlowin   = zin_q;
  assign bus.Zhighout = zhighout_q;
  assign bus.Zlowout  = zlowout_q;
  assign bus.HIin     = hiin_q;
  assign bus.LOin     = loin_q;
  assign bus.op       = op_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb/tb_alu_seq_ctrl.sv - self-checking bench for alu_seq_ctrl
module tb_alu_seq_ctrl;
  import alu_seq_ctrl_pkg::*;

  logic Clock = 1'b0;
  logic clear = 1'b1;
  always #5 Clock = ~Clock;

  alu_seq_ctrl_if #(.NREG(16), .OP_W(5)) bus ();

  alu_seq_ctrl #(
    .NREG(16), .OP_W(5), .OP_MUL(OP_MUL), .OP_DIV(OP_DIV)
  ) dut (
    .Clock (Clock),
    .clear (clear),
    .bus   (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // ---------------- behavioural model: phase within the command ----------
  // phase 0 = idle, 1..3 (or 1..4 for MUL/DIV) = cycles after the accept edge
  int         m_phase = 0;
  logic [4:0] m_op = '0;
  logic [3:0] m_ra = '0, m_rb = '0, m_rd = '0;

  always @(posedge Clock or posedge clear) begin
    if (clear) begin
      m_phase <= 0;
    end else if (m_phase == 0) begin
      if (bus.start) begin
        m_op    <= bus.op_in;
        m_ra    <= bus.ra;
        m_rb    <= bus.rb;
        m_rd    <= bus.rd;
        m_phase <= 1;
      end
    end else if (m_phase >= (((m_op == OP_MUL) || (m_op == OP_DIV)) ? 4 : 3)) begin
      m_phase <= 0;
    end else begin
      m_phase <= m_phase + 1;
    end
  end

  // ---------------- datapath stand-in driven by the strobes -------------
  logic [31:0] regs [16];
  logic [31:0] y_r, hi_r, lo_r;
  logic [63:0] z_r;
  int          rin_cnt = 0;
  logic        pk_en [16];
  logic [31:0] pk_val [16];

  function automatic logic [63:0] alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      OP_SLL:  return {32'd0, a << b[4:0]};
      OP_ADD:  return {32'd0, a + b};
      OP_MUL:  return {32'd0, a} * {32'd0, b};
      OP_DIV:  return (b == 0) ? 64'd0 : {a % b, a / b};
      default: return {32'd0, a ^ b};
    endcase
  endfunction

  always @(negedge Clock) begin
    logic [31:0] b;
    logic [63:0] r;
    b = '0;
    for (int i = 0; i < 16; i++) if (bus.Rout[i]) b = b | regs[i];
    if (bus.Zlowout)  b = b | z_r[31:0];
    if (bus.Zhighout) b = b | z_r[63:32];
    r = alu(bus.op, y_r, b);
    if (bus.Yin)     y_r <= b;
    if (bus.Zlowin)  z_r[31:0]  <= r[31:0];
    if (bus.Zhighin) z_r[63:32] <= r[63:32];
    if (bus.HIin) hi_r <= b;
    if (bus.LOin) lo_r <= b;
    if (bus.Rin != '0) rin_cnt <= rin_cnt + 1;
    for (int i = 0; i < 16; i++) begin
      if (bus.Rin[i]) regs[i] <= b;
      if (pk_en[i])   regs[i] <= pk_val[i];
    end
  end

  // ---------------- checking ----------------
  function automatic logic [45:0] dut_vec();
    return {bus.ready, bus.done, bus.Rout, bus.Rin, bus.Yin, bus.Zhighin, bus.Zlowin,
            bus.Zhighout, bus.Zlowout, bus.HIin, bus.LOin, bus.op};
  endfunction

  function automatic logic [45:0] model_vec();
    logic        md;
    logic [15:0] e_rout, e_rin;
    md     = (m_op == OP_MUL) || (m_op == OP_DIV);
    e_rout = (m_phase == 1) ? (16'd1 << m_ra) : (m_phase == 2) ? (16'd1 << m_rb) : 16'd0;
    e_rin  = (m_phase == 3 && !md) ? (16'd1 << m_rd) : 16'd0;
    return {m_phase == 0, (m_phase == 3 && !md) || m_phase == 4, e_rout, e_rin,
            m_phase == 1, m_phase == 2, m_phase == 2, m_phase == 4, m_phase == 3,
            m_phase == 4, m_phase == 3 && md, (m_phase == 2) ? m_op : 5'd0};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock: compare the current cycle against the model, then advance.
  task automatic step();
    @(negedge Clock);
    chk("cycle_vs_model", {18'd0, dut_vec()}, {18'd0, model_vec()});
    @(posedge Clock);
    #1;
  endtask

  task automatic poke(input int idx, input logic [31:0] val);
    pk_en[idx]  = 1'b1;
    pk_val[idx] = val;
  endtask

  task automatic unpoke();
    for (int i = 0; i < 16; i++) pk_en[i] = 1'b0;
  endtask

  task automatic issue(input logic [4:0] op, input logic [3:0] a, input logic [3:0] b, input logic [3:0] d);
    bus.op_in = op;
    bus.ra    = a;
    bus.rb    = b;
    bus.rd    = d;
    bus.start = 1'b1;
    step();
    unpoke();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.ready !== 1'b1 && n < 12) begin
      step();
      n++;
    end
    chk("wait_idle_ready", {63'd0, bus.ready}, 64'd1);
  endtask

  int rc;

  initial begin
    unpoke();
    bus.start = 1'b0; bus.op_in = '0; bus.ra = '0; bus.rb = '0; bus.rd = '0;

    // Reset held for two cycles.
    step(); step();
    chk("reset_ready", {63'd0, bus.ready}, 64'd1);
    chk("reset_strobes", {19'd0, dut_vec()[44:0]}, 64'd0);
    clear = 1'b0;
    step();

    // SLL: R1 = 12 << 5
    poke(2, 32'd12); poke(3, 32'd5);
    issue(OP_SLL, 4'd2, 4'd3, 4'd1);
    bus.start = 1'b0;
    chk("sll_c1_rout", {48'd0, bus.Rout}, 64'h0004);
    chk("sll_c1_yin", {63'd0, bus.Yin}, 64'd1);
    step();
    chk("sll_c2_rout", {48'd0, bus.Rout}, 64'h0008);
    chk("sll_c2_op", {59'd0, bus.op}, 64'd3);
    chk("sll_c2_zin", {62'd0, bus.Zhighin, bus.Zlowin}, 64'd3);
    step();
    chk("sll_c3_rin", {48'd0, bus.Rin}, 64'h0002);
    chk("sll_c3_zlo_done", {62'd0, bus.Zlowout, bus.done}, 64'd3);
    step();
    chk("sll_r1", {32'd0, regs[1]}, 64'd384);

    // MUL: 0x10000 * 0x10000 -> HI=1, LO=0, no register write.
    poke(4, 32'h10000); poke(5, 32'h10000);
    issue(OP_MUL, 4'd4, 4'd5, 4'd6);
    bus.start = 1'b0;
    rc = rin_cnt;
    step(); step();
    chk("mul_c3_loin", {62'd0, bus.LOin, bus.done}, 64'd2);
    chk("mul_c3_rin", {48'd0, bus.Rin}, 64'd0);
    step();
    chk("mul_c4_hiin_done", {61'd0, bus.HIin, bus.Zhighout, bus.done}, 64'd7);
    step();
    chk("mul_hi", {32'd0, hi_r}, 64'd1);
    chk("mul_lo", {32'd0, lo_r}, 64'd0);
    chk("mul_no_rin", rin_cnt - rc, 64'd0);

    // start held high: only first command runs; second accepted on ready.
    issue(OP_ADD, 4'd1, 4'd2, 4'd10);
    bus.rd = 4'd11;
    step();
    bus.rd = 4'd12;
    step();
    chk("held_c3_rin", {48'd0, bus.Rin}, 64'h0400);
    bus.ra = 4'd3; bus.rd = 4'd13;
    step();
    chk("held_c4_ready", {63'd0, bus.ready}, 64'd1);
    step();
    chk("held_c5_busy", {63'd0, bus.ready}, 64'd0);
    chk("held_c5_rout", {48'd0, bus.Rout}, 64'h0008);
    bus.start = 1'b0;
    wait_idle();

    // Inputs changed after accept have no effect.
    issue(OP_ADD, 4'd0, 4'd1, 4'd4);
    bus.start = 1'b0; bus.ra = 4'd5; bus.rb = 4'd6; bus.rd = 4'd9;
    step();
    chk("late_c2_rout", {48'd0, bus.Rout}, 64'h0002);
    step();
    chk("late_c3_rin", {48'd0, bus.Rin}, 64'h0010);
    wait_idle();

    // Aliasing: R7 = R7 + R7.
    poke(7, 32'd9);
    issue(OP_ADD, 4'd7, 4'd7, 4'd7);
    bus.start = 1'b0;
    step(); step(); step();
    chk("alias_r7", {32'd0, regs[7]}, 64'd18);

    // clear during EXEC abandons the command.
    issue(OP_ADD, 4'd1, 4'd2, 4'd9);
    bus.start = 1'b0;
    step();
    clear = 1'b1;
    #1;
    chk("clr_exec_strobes", {19'd0, dut_vec()[44:0]}, 64'd0);
    chk("clr_exec_ready", {63'd0, bus.ready}, 64'd1);
    rc = rin_cnt;
    step();
    clear = 1'b0;
    repeat (4) step();
    chk("clr_no_rin", rin_cnt - rc, 64'd0);

    // Random traffic against the model.
    for (int k = 0; k < 500; k++) begin
      bus.start = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 4))
        0: bus.op_in = OP_SLL;
        1: bus.op_in = OP_ADD;
        2: bus.op_in = OP_MUL;
        3: bus.op_in = OP_DIV;
        default: bus.op_in = 5'($urandom);
      endcase
      bus.ra = 4'($urandom);
      bus.rb = 4'($urandom);
      bus.rd = 4'($urandom);
      clear  = ($urandom_range(0, 39) == 0);
      step();
    end
    clear = 1'b0;
    bus.start = 1'b0;
    wait_idle();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
